// File: rtl/qadd_arb_if.sv
// Request/result bundle between the adder clients and the shared qadd_arb scheduler.
// The slave modport is the scheduler side; master is the client/consumer side.
interface qadd_arb_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 32,
   parameter int unsigned IW = $clog2(N)
);
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_data;
   logic [IW-1:0]  res_id;
   logic           res_ovf;
   logic           busy;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_data, res_id, res_ovf, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_data, res_id, res_ovf, busy
   );
endinterface

// File: rtl/qadd_arb.sv
// Round-robin scheduler sharing one sign-magnitude adder among N requesters.
// One operation in flight: IDLE grants and captures, CALC adds, RESP holds the result.
module qadd_arb #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   qadd_arb_if.slave    bus_io
);
   localparam int unsigned IW = $clog2(N);
   localparam logic [IW:0] NumReq = (IW+1)'(N);

   typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] gnt_q, gnt_d;
   logic [W-1:0]  opa_q, opa_d, opb_q, opb_d;
   logic [W-1:0]  res_data_q, res_data_d;
   logic [IW-1:0] res_id_q, res_id_d;
   logic          res_ovf_q, res_ovf_d;

   // Round-robin pick: rotate so rr_ptr sits at bit 0, take lowest set bit, rotate back.
   logic [N-1:0]  rot;
   logic          gnt_found;
   logic [IW:0]   gnt_off, gnt_sum;
   logic [IW-1:0] gnt_idx;
   logic [W-1:0]  sel_a, sel_b;

   always_comb begin
      rot       = N'({bus_io.req_valid, bus_io.req_valid} >> rr_ptr_q);
      gnt_found = |rot;
      gnt_off   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) gnt_off = (IW+1)'(i);
      end
      gnt_sum = {1'b0, rr_ptr_q} + gnt_off;
      gnt_idx = (gnt_sum >= NumReq) ? IW'(gnt_sum - NumReq) : gnt_sum[IW-1:0];
      sel_a   = '0;
      sel_b   = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_a = bus_io.req_a[i*W +: W];
            sel_b = bus_io.req_b[i*W +: W];
         end
      end
   end

   // Sign-magnitude adder on the captured operands.
   logic           sa, sb, sum_sgn, sum_ovf;
   logic [W-2:0]   ma, mb, sum_mag;
   logic [W-1:0]   mag_add;

   always_comb begin
      sa      = opa_q[W-1];
      sb      = opb_q[W-1];
      ma      = opa_q[W-2:0];
      mb      = opb_q[W-2:0];
      mag_add = {1'b0, ma} + {1'b0, mb};
      sum_mag = '0;
      sum_sgn = 1'b0;
      sum_ovf = 1'b0;
      if (sa == sb) begin
         sum_mag = mag_add[W-2:0];
         sum_sgn = sa;
         sum_ovf = mag_add[W-1];
      end else if (ma >= mb) begin
         sum_mag = ma - mb;
         sum_sgn = sa;
      end else begin
         sum_mag = mb - ma;
         sum_sgn = sb;
      end
      if (sum_mag == '0) sum_sgn = 1'b0;
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_d      = gnt_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      res_ovf_d  = res_ovf_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_found) begin
               state_d  = StCalc;
               opa_d    = sel_a;
               opb_d    = sel_b;
               gnt_d    = gnt_idx;
               rr_ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
         end
         StCalc: begin
            state_d    = StResp;
            res_data_d = {sum_sgn, sum_mag};
            res_ovf_d  = sum_ovf;
            res_id_d   = gnt_q;
         end
         StResp: begin
            if (bus_io.res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         res_data_q <= '0;
         res_id_q   <= '0;
         res_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_q      <= gnt_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_ovf_q  <= res_ovf_d;
      end
   end

   // Gated by rst_n so req_ready is low while reset is held, even with valids asserted.
   assign bus_io.req_ready = (rst_n && state_q == StIdle && gnt_found) ? (N'(1) << gnt_idx) : '0;
   assign bus_io.res_valid = (state_q == StResp);
   assign bus_io.busy      = (state_q != StIdle);
   assign bus_io.res_data  = res_data_q;
   assign bus_io.res_id    = res_id_q;
   assign bus_io.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_qadd_arb.sv
// Bench for qadd_arb: cycle-by-cycle compare against a signed-integer model of the
// scheduler, plus directed vectors with hand-computed results.
module tb_qadd_arb;
   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   qadd_arb_if #(.N(N), .W(W)) bus ();

   qadd_arb #(.N(N), .W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Result as signed integer arithmetic: {ovf, sign, magnitude}.
   function automatic logic [32:0] model_add(logic [31:0] a, logic [31:0] b);
      longint va, vb, s, m, mg;
      logic [30:0] mag;
      logic ovf, sgn;
      va = longint'(a[30:0]);
      vb = longint'(b[30:0]);
      if (a[31]) va = -va;
      if (b[31]) vb = -vb;
      s   = va + vb;
      m   = (s < 0) ? -s : s;
      ovf = (m >= (longint'(1) << 31));
      mg  = m & 64'h7FFF_FFFF;
      mag = mg[30:0];
      sgn = (s < 0) && (mag != '0);
      return {ovf, sgn, mag};
   endfunction

   // Model state: 0 idle, 1 computing, 2 result pending.
   int          m_st = 0, m_rr = 0, m_id = 0, g;
   logic [31:0] m_data = '0;
   logic        m_ovf = 1'b0;
   logic [N-1:0] er;
   logic [32:0] mr;

   logic [31:0] log_data[$];
   int          log_id[$];
   logic        log_ovf[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", bus.req_ready, '0);
         chk("rst_res_valid", bus.res_valid, 1'b0);
         chk("rst_busy", bus.busy, 1'b0);
         chk("rst_res_data", bus.res_data, '0);
         m_st = 0;
         m_rr = 0;
      end else begin
         er = '0;
         g  = -1;
         if (m_st == 0) begin
            for (int k = 0; k < N; k++) begin
               if (g < 0 && bus.req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
         end
         if (g >= 0) er[g] = 1'b1;
         chk("req_ready", bus.req_ready, er);
         chk("req_ready_onehot", ($countones(bus.req_ready) <= 1), 1'b1);
         chk("busy", bus.busy, (m_st != 0));
         chk("res_valid", bus.res_valid, (m_st == 2));
         case (m_st)
            2: begin
               chk("res_data", bus.res_data, m_data);
               chk("res_id", bus.res_id, m_id);
               chk("res_ovf", bus.res_ovf, m_ovf);
               if (bus.res_ready) begin
                  log_data.push_back(bus.res_data);
                  log_id.push_back(int'(bus.res_id));
                  log_ovf.push_back(bus.res_ovf);
                  m_st = 0;
               end
            end
            1: m_st = 2;
            default: begin
               if (g >= 0) begin
                  mr     = model_add(bus.req_a[g*W +: W], bus.req_b[g*W +: W]);
                  m_ovf  = mr[32];
                  m_data = mr[31:0];
                  m_id   = g;
                  m_rr   = (g + 1) % N;
                  m_st   = 1;
               end
            end
         endcase
      end
   end

   task automatic set_op(int i, logic [31:0] a, logic [31:0] b);
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
   endtask

   task automatic wait_res(string name);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!bus.res_valid && c < 20);
      if (!bus.res_valid) timeout(name);
   endtask

   task automatic do_op(string name, int i, logic [31:0] a, logic [31:0] b);
      int c = 0;
      @(posedge clk); #1;
      set_op(i, a, b);
      bus.req_valid = '0;
      bus.req_valid[i] = 1'b1;
      do begin
         @(negedge clk);
         c++;
      end while (!bus.req_ready[i] && c < 20);
      if (!bus.req_ready[i]) timeout(name);
      @(posedge clk); #1;
      bus.req_valid = '0;
      wait_res(name);
      @(posedge clk); #1;
   endtask

   task automatic check_last(string nm, logic [31:0] d, int id, logic ovf);
      if (log_data.size() == 0) begin
         timeout({nm, "_nolog"});
      end else begin
         chk({nm, "_data"}, log_data[$], d);
         chk({nm, "_id"}, log_id[$], id);
         chk({nm, "_ovf"}, log_ovf[$], ovf);
      end
   endtask

   task automatic wait_log(string name, int target);
      int c = 0;
      do begin
         @(posedge clk);
         c++;
      end while (log_data.size() < target && c < 80);
      if (log_data.size() < target) timeout(name);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   int base;
   int exp_ids[7] = '{0, 1, 2, 3, 0, 3, 0};

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b1;
      #1;
      chk("reset_busy", bus.busy, 1'b0);
      chk("reset_res_id", bus.res_id, '0);
      chk("reset_res_ovf", bus.res_ovf, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Single op with latency checks.
      @(posedge clk); #1;
      set_op(0, 32'h0000_0005, 32'h0000_0003);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      chk("t1_req_ready", bus.req_ready, 4'b0001);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      chk("t1_calc_res_valid", bus.res_valid, 1'b0);
      chk("t1_calc_busy", bus.busy, 1'b1);
      @(negedge clk);
      chk("t1_res_valid", bus.res_valid, 1'b1);
      chk("t1_res_data", bus.res_data, 32'h0000_0008);
      chk("t1_res_id", bus.res_id, 0);
      chk("t1_res_ovf", bus.res_ovf, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("t1_idle_busy", bus.busy, 1'b0);

      do_op("mix1", 1, 32'h0000_0005, 32'h8000_0003);
      check_last("mix1", 32'h0000_0002, 1, 1'b0);
      do_op("mix2", 2, 32'h0000_0003, 32'h8000_0005);
      check_last("mix2", 32'h8000_0002, 2, 1'b0);
      do_op("mix3", 3, 32'h8000_0004, 32'h0000_0004);
      check_last("mix3", 32'h0000_0000, 3, 1'b0);
      do_op("mix4", 0, 32'h8000_0002, 32'h8000_0003);
      check_last("mix4", 32'h8000_0005, 0, 1'b0);
      do_op("ovf1", 1, 32'h7FFF_FFFF, 32'h0000_0001);
      check_last("ovf1", 32'h0000_0000, 1, 1'b1);
      do_op("ovf2", 2, 32'hFFFF_FFFF, 32'h8000_0002);
      check_last("ovf2", 32'h8000_0001, 2, 1'b1);

      // Round-robin from rr_ptr=0 with all requesters held valid.
      pulse_reset();
      for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'h0000_0010);
      base = log_data.size();
      @(posedge clk); #1;
      bus.req_valid = 4'b1111;
      wait_log("rr_all", base + 5);
      #1 bus.req_valid = 4'b1001;
      wait_log("rr_two", base + 7);
      #1 bus.req_valid = '0;
      if (log_data.size() >= base + 7) begin
         for (int k = 0; k < 7; k++) chk($sformatf("rr_id%0d", k), log_id[base + k], exp_ids[k]);
         chk("rr_data1", log_data[base + 1], 32'h0000_0012);
      end

      // Backpressure: result held 5 cycles, requester 1 is next in line.
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.req_valid = 4'b1111;
      wait_res("bp_first");
      for (int k = 0; k < 5; k++) begin
         chk("bp_res_valid", bus.res_valid, 1'b1);
         chk("bp_res_data", bus.res_data, 32'h0000_0012);
         chk("bp_res_id", bus.res_id, 1);
         chk("bp_req_ready", bus.req_ready, '0);
         if (k < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", bus.res_valid, 1'b1);
      @(negedge clk);
      chk("bp_next_accept", bus.req_ready, 4'b0100);
      @(posedge clk); #1;
      bus.req_valid = '0;
      wait_res("bp_second");
      @(posedge clk); #1;
      check_last("bp_second", 32'h0000_0013, 2, 1'b0);

      // Reset while an operation is in CALC; requester 2 keeps requesting.
      set_op(2, 32'h8000_0007, 32'h0000_0002);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk("rst_grant_before", bus.req_ready, 4'b0100);
      base = log_data.size();
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", bus.busy, 1'b0);
      chk("rstmid_res_valid", bus.res_valid, 1'b0);
      chk("rstmid_req_ready", bus.req_ready, '0);
      chk("rstmid_res_data", bus.res_data, '0);
      chk("rstmid_res_id", bus.res_id, '0);
      chk("rstmid_res_ovf", bus.res_ovf, 1'b0);
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_grant_after", bus.req_ready, 4'b0100);
      @(posedge clk); #1;
      bus.req_valid = '0;
      wait_res("rst_result");
      @(posedge clk); #1;
      chk("rst_log_count", log_data.size(), base + 1);
      check_last("rst_result", 32'h8000_0005, 2, 1'b0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/qadd_arb.md
# qadd_arb

Round-robin scheduler that shares one 32-bit sign-magnitude fixed-point adder among N requesters. It accepts one operand pair at a time over a valid/ready handshake, computes the sign-magnitude sum, and returns it on a single result channel. The result is tagged with the requester index and carries an overflow flag. It sits between the filter/accumulator clients and the fixed-point arithmetic datapath, so that only one adder instance is needed.

## Interface
- N, 4, number of requesters (2..8)
- W, 32, word width; bit W-1 is sign, bits W-2:0 are magnitude
- IW, $clog2(N), width of requester index
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N  per-requester operand valid
- req_ready  output  N  per-requester accept; at most one bit high
- req_a  input  N*W  operand A, requester i at [i*W +: W]
- req_b  input  N*W  operand B, same packing
- res_valid  output  1  result valid
- res_ready  input  1  result consumer accept
- res_data  output  W  sign-magnitude sum
- res_id  output  IW  index of requester that issued the operation
- res_ovf  output  1  magnitude overflow on same-sign add
- busy  output  1  high in any state other than IDLE

## Operation
- The FSM has three states: IDLE, CALC and RESP. Reset enters IDLE.
- IDLE:
  - If any req_valid is high, grant the first valid requester found scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... mod N).
  - req_ready[grant] is driven combinationally high in this cycle only.
  - On the edge: capture req_a/req_b of the grant into operand registers, store the grant index, set rr_ptr = (grant+1) mod N, and go to CALC.
  - With no req_valid high, remain in IDLE.
- CALC: the combinational adder evaluates the captured operands. On the edge, register res_data/res_ovf/res_id and go to RESP.
- RESP:
  - res_valid is high.
  - When res_ready is high on the edge, go to IDLE.
  - Otherwise hold; res_data, res_id and res_ovf stay stable.
- req_ready is all-zero in CALC and RESP. Requesters hold valid and data until they are granted.
- Arithmetic, with sa/sb the signs and ma/mb the (W-1)-bit magnitudes:
  - Same sign: {carry, mag} = ma + mb; sign = sa; ovf = carry; mag is truncated to W-1 bits.
  - Different sign, ma >= mb: mag = ma - mb, sign = sa.
  - Different sign, ma < mb: mag = mb - ma, sign = sb.
  - In both different-sign cases ovf = 0.
  - If mag == 0 then sign = 0; negative zero is never output. Inputs of negative zero are treated as magnitude 0.
- rr_ptr is IW bits and resets to 0. Fairness: any requester holding req_valid is granted within N grants.

## Timing
- Reset values: req_ready=0, res_valid=0, res_data=0, res_id=0, res_ovf=0, busy=0, rr_ptr=0, state=IDLE.
- Assertion of rst_n takes effect immediately, not on a clock edge, in any state. An in-flight operation is discarded and produces no res_valid. Deassertion is synchronized externally.
- Latency:
  - Accept edge T (req_valid & req_ready).
  - res_valid rises after edge T+1, i.e. 2 cycles after accept.
  - The earliest next accept is in the cycle after the res handshake edge.
- Throughput: at most 1 operation per 3 cycles with res_ready held high.
- req_ready may depend combinationally on req_valid. No other combinational path exists from inputs to outputs.
- res_ready is ignored outside RESP.
- busy = (state != IDLE).

## Test plan
- Single op, requester 0, a=0x00000005, b=0x00000003, res_ready=1 -> req_ready[0] high for 1 cycle; res_valid 2 cycles later, res_data=0x00000008, res_id=0, res_ovf=0; then busy=0.
- Mixed signs, one op each:
  - 0x00000005+0x80000003 -> 0x00000002.
  - 0x00000003+0x80000005 -> 0x80000002.
  - 0x80000004+0x00000004 -> 0x00000000.
  - 0x80000002+0x80000003 -> 0x80000005.
  - All have ovf=0.
- Overflow:
  - 0x7FFFFFFF+0x00000001 -> res_data=0x00000000, res_ovf=1.
  - 0xFFFFFFFF+0x80000002 -> 0x80000001, res_ovf=1.
- Round-robin:
  - All 4 req_valid held -> res_id sequence 0,1,2,3,0.
  - Then only requesters 0 and 3 valid, with rr_ptr=1 -> grants 3 then 0.
  - Never two req_ready bits high in the same cycle.
- Backpressure: res_ready=0 for 5 cycles in RESP -> res_valid, res_data and res_id are constant; req_ready=0 throughout despite all req_valid=1. After res_ready=1, the next accept occurs exactly 1 cycle after the handshake.
- Reset mid-operation: rst_n low during CALC -> all outputs 0 without waiting for an edge; no res_valid appears. After release with req_valid[2] still high, requester 2 is granted, scanning from rr_ptr=0, and produces the correct sum.
